multi_channel_player_control: RTL

- Parametrised successor to the per-channel beat counters. One instance drives NCH independent beat indices (ibeat) into the note-lookup and tone-generation path.
- Each channel has its own restart-on-state-change, runtime length, loop/hold mode and pause.
- Advance is gated by a shared beat_tick, so the block runs on the system clock instead of a divided clock.
- State-change restart is fully synchronous; there is no edge-triggered reset path.

---
 rtl/multi_channel_player_control_pkg.sv | 20 ++
 rtl/multi_channel_player_control_beat_channel.sv | 80 ++++++++
 rtl/multi_channel_player_control.sv | 40 ++++
 3 files changed

// File: rtl/multi_channel_player_control_pkg.sv
// Shared encodings for the multi-channel beat player: loop/hold mode and
// the per-channel state codes driven by the game sequencer.
package player_pkg;

    localparam logic LOOP_WRAP = 1'b1;
    localparam logic LOOP_HOLD = 1'b0;

    typedef enum logic [1:0] {
        SILENCE    = 2'd0,
        GOOD_BALL  = 2'd1,
        BAD_BALL   = 2'd2,
        HIGH_SCORE = 2'd3
    } r_state_e;

    typedef enum logic [1:0] {
        WAIT_DEPOSIT = 2'd0,
        WAIT_PLAYING = 2'd1
    } l_state_e;

endpackage

// File: rtl/multi_channel_player_control_beat_channel.sv
// One beat channel: restarts on any state-code change, otherwise steps its
// beat index on beat_tick, wrapping (loop) or clamping on the last beat (hold).
module beat_channel
    import player_pkg::*;
#(
    parameter int BEAT_W  = 10,
    parameter int STATE_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               beat_tick,
    input  logic [STATE_W-1:0] state,
    input  logic [BEAT_W-1:0]  len,
    input  logic               loop_en,
    input  logic               pause,
    output logic [BEAT_W-1:0]  ibeat,
    output logic               done,
    output logic               wrap_pulse
);

    logic [STATE_W-1:0] prev_state_q, prev_state_d;
    logic [BEAT_W-1:0]  ibeat_q, ibeat_d;
    logic               done_q, done_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic [BEAT_W-1:0]  eff_len;
    logic [BEAT_W-1:0]  last_beat;

    // A zero length behaves as a single-beat sequence.
    assign eff_len   = (len == '0) ? BEAT_W'(1) : len;
    assign last_beat = eff_len - BEAT_W'(1);

    always_comb begin
        prev_state_d = state;
        ibeat_d      = ibeat_q;
        done_d       = done_q;
        wrap_pulse_d = 1'b0;
        if (state != prev_state_q) begin
            ibeat_d = '0;
            done_d  = 1'b0;
        end else if (beat_tick && !pause) begin
            if (loop_en == LOOP_WRAP) begin
                done_d = 1'b0;
                if (ibeat_q < last_beat) begin
                    ibeat_d = ibeat_q + BEAT_W'(1);
                end else begin
                    ibeat_d      = '0;
                    wrap_pulse_d = 1'b1;
                end
            end else begin
                // ">=" also catches an index left beyond a freshly shrunk length.
                if (ibeat_q < last_beat) begin
                    ibeat_d = ibeat_q + BEAT_W'(1);
                    done_d  = 1'b0;
                end else begin
                    ibeat_d = last_beat;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_state_q <= '0;
            ibeat_q      <= '0;
            done_q       <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            prev_state_q <= prev_state_d;
            ibeat_q      <= ibeat_d;
            done_q       <= done_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign ibeat      = ibeat_q;
    assign done       = done_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: rtl/multi_channel_player_control.sv
// NCH independent beat channels sharing one beat_tick; each channel owns a
// slice of the packed state/len/ibeat buses.
module multi_channel_player_control
    import player_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int BEAT_W  = 10,
    parameter int STATE_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat_tick,
    input  logic [NCH*STATE_W-1:0] state,
    input  logic [NCH*BEAT_W-1:0]  len,
    input  logic [NCH-1:0]         loop_en,
    input  logic [NCH-1:0]         pause,
    output logic [NCH*BEAT_W-1:0]  ibeat,
    output logic [NCH-1:0]         done,
    output logic [NCH-1:0]         wrap_pulse
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        beat_channel #(
            .BEAT_W  (BEAT_W),
            .STATE_W (STATE_W)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .beat_tick  (beat_tick),
            .state      (state[c*STATE_W +: STATE_W]),
            .len        (len[c*BEAT_W +: BEAT_W]),
            .loop_en    (loop_en[c]),
            .pause      (pause[c]),
            .ibeat      (ibeat[c*BEAT_W +: BEAT_W]),
            .done       (done[c]),
            .wrap_pulse (wrap_pulse[c])
        );
    end

endmodule
